multi_digit_bcd_counter: RTL and testbench

MULTI_DIGIT_BCD_COUNTER -- requirements
Module: multi_digit_bcd_counter

---
 rtl/multi_digit_bcd_counter_pkg.sv | 10 +
 rtl/multi_digit_bcd_counter_bcd_digit.sv | 37 +++
 rtl/multi_digit_bcd_counter.sv | 50 +++++
 tb/tb_multi_digit_bcd_counter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/multi_digit_bcd_counter_pkg.sv
// multi_digit_bcd_counter_pkg: shared BCD digit constants and load-value clamp.
package multi_digit_bcd_counter_pkg;
    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction
endpackage

// File: rtl/multi_digit_bcd_counter_bcd_digit.sv
// bcd_digit: one 8421 BCD digit register with load, step and at-limit flag.
// Down stepping exists only when BCD_COUNTER_UPDOWN_EN is defined.
module bcd_digit
    import multi_digit_bcd_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             step,
`ifdef BCD_COUNTER_UPDOWN_EN
    input  logic             up,
`endif
    output logic [BCD_W-1:0] digit,
    output logic             at_lim
);
    logic [BCD_W-1:0] digit_q, digit_d, step_val;

    always_comb begin
`ifdef BCD_COUNTER_UPDOWN_EN
        step_val = up ? ((digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1)
                      : ((digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1);
        at_lim   = digit_q == (up ? BCD_MAX : BCD_MIN);
`else
        step_val = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
        at_lim   = digit_q == BCD_MAX;
`endif
        digit_d  = load ? bcd_clamp(ld_val) : step ? step_val : digit_q;
    end

    always_ff @(posedge clk) begin
        if (rst) digit_q <= BCD_MIN;
        else     digit_q <= digit_d;
    end

    assign digit = digit_q;
endmodule

// File: rtl/multi_digit_bcd_counter.sv
// multi_digit_bcd_counter: cascaded BCD counter with load, wrap/saturate and terminal count.
// Define BCD_COUNTER_UPDOWN_EN to add the up port and down counting.
module multi_digit_bcd_counter
    import multi_digit_bcd_counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
`ifdef BCD_COUNTER_UPDOWN_EN
    input  logic                  up,
`endif
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  co
);
    logic [DIGITS-1:0] step, at_lim;
    logic              ripple;

    assign tc = &at_lim;
    assign co = en & tc & ~load;

    // A digit steps when every lower digit is at its limit; saturation blocks the whole chain.
    always_comb begin
        ripple = en & ~load & ~(tc & (WRAP == 0));
        for (int k = 0; k < DIGITS; k++) begin
            step[k] = ripple;
            ripple  = ripple & at_lim[k];
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk    (clk),
            .rst    (rst),
            .load   (load),
            .ld_val (d[i*BCD_W +: BCD_W]),
            .step   (step[i]),
`ifdef BCD_COUNTER_UPDOWN_EN
            .up     (up),
`endif
            .digit  (q[i*BCD_W +: BCD_W]),
            .at_lim (at_lim[i])
        );
    end
endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// tb_multi_digit_bcd_counter: randomized and directed checks of a wrapping and a saturating
// 2-digit counter against a decimal-integer reference model.
module tb_multi_digit_bcd_counter;
    logic       clk = 1'b0;
    logic       rst, en, load, up;
    logic [7:0] d;
    logic [7:0] q_w, q_s;
    logic       tc_w, co_w, tc_s, co_s;
    int         mw, ms;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    multi_digit_bcd_counter #(.DIGITS(2), .WRAP(1)) dut_w (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d),
`ifdef BCD_COUNTER_UPDOWN_EN
        .up(up),
`endif
        .q(q_w), .tc(tc_w), .co(co_w));

    multi_digit_bcd_counter #(.DIGITS(2), .WRAP(0)) dut_s (
        .clk(clk), .rst(rst), .en(en), .load(load), .d(d),
`ifdef BCD_COUNTER_UPDOWN_EN
        .up(up),
`endif
        .q(q_s), .tc(tc_s), .co(co_s));

    function automatic int clamp9(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    function automatic logic [7:0] enc(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic int next_val(input int v, input bit wrap);
        if (rst) return 0;
        if (load) return clamp9(int'(d[7:4])) * 10 + clamp9(int'(d[3:0]));
        if (!en) return v;
        if (up) return (v == 99) ? (wrap ? 0 : 99) : v + 1;
        return (v == 0) ? (wrap ? 99 : 0) : v - 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        mw = next_val(mw, 1'b1);
        ms = next_val(ms, 1'b0);
        #1;
    endtask

    task automatic set_in(input bit r, input bit l, input bit e, input bit u, input logic [7:0] dv);
        rst = r; load = l; en = e; d = dv;
`ifdef BCD_COUNTER_UPDOWN_EN
        up = u;
`else
        up = 1'b1;
`endif
    endtask

    task automatic test_reset();
        set_in(1, 1, 1, 1, 8'h55);
        tick();
        set_in(0, 0, 0, 1, 8'h00);
        #1;
        checks++; if (q_w !== 8'h00) begin errors++; $display("FAIL reset_q_w got %h want 00", q_w); end
        checks++; if (q_s !== 8'h00) begin errors++; $display("FAIL reset_q_s got %h want 00", q_s); end
        checks++; if (tc_w !== 1'b0) begin errors++; $display("FAIL reset_tc got %b want 0", tc_w); end
        checks++; if (co_w !== 1'b0) begin errors++; $display("FAIL reset_co got %b want 0", co_w); end
    endtask

    task automatic test_up_sweep();
        set_in(0, 0, 1, 1, 8'h00);
        for (int i = 1; i <= 100; i++) begin
            tick();
            checks++; if (q_w !== enc(mw)) begin errors++; $display("FAIL sweep_q step %0d got %h want %h", i, q_w, enc(mw)); end
            checks++; if (tc_w !== (mw == 99)) begin errors++; $display("FAIL sweep_tc step %0d got %b want %b", i, tc_w, mw == 99); end
            checks++; if (co_w !== (mw == 99)) begin errors++; $display("FAIL sweep_co step %0d got %b want %b", i, co_w, mw == 99); end
            checks++; if (q_s !== enc(ms)) begin errors++; $display("FAIL sweep_qs step %0d got %h want %h", i, q_s, enc(ms)); end
            if (i == 99) begin
                checks++; if (q_w !== 8'h99 || tc_w !== 1'b1) begin errors++; $display("FAIL sweep_99 got %h/%b want 99/1", q_w, tc_w); end
            end
        end
        checks++; if (q_w !== 8'h00) begin errors++; $display("FAIL sweep_wrap got %h want 00", q_w); end
    endtask

    task automatic test_saturate();
        set_in(0, 1, 0, 1, 8'h98);
        tick();
        checks++; if (q_s !== 8'h98) begin errors++; $display("FAIL sat_load got %h want 98", q_s); end
        set_in(0, 0, 1, 1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q_s !== 8'h99) begin errors++; $display("FAIL sat_hold %0d got %h want 99", i, q_s); end
            checks++; if (tc_s !== 1'b1) begin errors++; $display("FAIL sat_tc %0d got %b want 1", i, tc_s); end
        end
    endtask

    task automatic test_load_clamp();
        set_in(0, 1, 1, 1, 8'h3C);
        #1;
        checks++; if (co_w !== 1'b0) begin errors++; $display("FAIL clamp_co_pre got %b want 0", co_w); end
        tick();
        checks++; if (q_w !== 8'h39) begin errors++; $display("FAIL clamp_q got %h want 39", q_w); end
        checks++; if (co_w !== 1'b0) begin errors++; $display("FAIL clamp_co got %b want 0", co_w); end
        checks++; if (q_w !== enc(mw)) begin errors++; $display("FAIL clamp_model got %h want %h", q_w, enc(mw)); end
    endtask

    task automatic test_rst_priority();
        set_in(0, 1, 0, 1, 8'h47);
        tick();
        checks++; if (q_w !== 8'h47) begin errors++; $display("FAIL rstp_load got %h want 47", q_w); end
        set_in(1, 1, 1, 1, 8'h55);
        tick();
        checks++; if (q_w !== 8'h00) begin errors++; $display("FAIL rstp_q got %h want 00", q_w); end
        checks++; if (q_s !== 8'h00) begin errors++; $display("FAIL rstp_qs got %h want 00", q_s); end
    endtask

`ifdef BCD_COUNTER_UPDOWN_EN
    task automatic test_down();
        set_in(0, 1, 0, 0, 8'h10);
        tick();
        set_in(0, 0, 1, 0, 8'h00);
        tick();
        checks++; if (q_w !== 8'h09) begin errors++; $display("FAIL down_09 got %h want 09", q_w); end
        tick();
        checks++; if (q_w !== 8'h08) begin errors++; $display("FAIL down_08 got %h want 08", q_w); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (q_w !== 8'h00 || tc_w !== 1'b1) begin errors++; $display("FAIL down_00 got %h/%b want 00/1", q_w, tc_w); end
        tick();
        checks++; if (q_w !== 8'h99) begin errors++; $display("FAIL down_wrap got %h want 99", q_w); end
        checks++; if (q_s !== 8'h00) begin errors++; $display("FAIL down_sat got %h want 00", q_s); end
    endtask
`endif

    task automatic test_dir_toggle();
        set_in(0, 1, 0, 1, 8'h50);
        tick();
`ifdef BCD_COUNTER_UPDOWN_EN
        set_in(0, 0, 1, 1, 8'h00);
        tick();
        checks++; if (q_w !== 8'h51) begin errors++; $display("FAIL dir_up got %h want 51", q_w); end
        set_in(0, 0, 1, 0, 8'h00);
        tick();
        checks++; if (q_w !== 8'h50) begin errors++; $display("FAIL dir_down got %h want 50", q_w); end
`endif
        set_in(0, 0, 0, 1, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (q_w !== 8'h50) begin errors++; $display("FAIL hold %0d got %h want 50", i, q_w); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 1) == 1, 8'($urandom));
            tick();
            checks++; if (q_w !== enc(mw)) begin errors++; $display("FAIL rand_qw %0d got %h want %h", i, q_w, enc(mw)); end
            checks++; if (q_s !== enc(ms)) begin errors++; $display("FAIL rand_qs %0d got %h want %h", i, q_s, enc(ms)); end
            checks++; if (tc_w !== (up ? mw == 99 : mw == 0)) begin errors++; $display("FAIL rand_tcw %0d got %b", i, tc_w); end
            checks++; if (tc_s !== (up ? ms == 99 : ms == 0)) begin errors++; $display("FAIL rand_tcs %0d got %b", i, tc_s); end
            checks++; if (co_w !== (en & ~load & (up ? mw == 99 : mw == 0))) begin errors++; $display("FAIL rand_cow %0d got %b", i, co_w); end
            checks++; if (co_s !== (en & ~load & (up ? ms == 99 : ms == 0))) begin errors++; $display("FAIL rand_cos %0d got %b", i, co_s); end
        end
    endtask

    initial begin
        mw = 0;
        ms = 0;
        set_in(1, 0, 0, 1, 8'h00);
        test_reset();
        test_up_sweep();
        test_saturate();
        test_load_clamp();
        test_rst_priority();
`ifdef BCD_COUNTER_UPDOWN_EN
        test_down();
`endif
        test_dir_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
